// File: rtl/mp_pipe_core_if.sv
// Instruction-in / result-out handshake bundle for mp_pipe_core.
// master = instruction source and result consumer, slave = the core.
interface mp_pipe_core_if #(
  parameter int DATA_W    = 32,
  parameter int REG_DEPTH = 32
);
  localparam int ADDR_W = $clog2(REG_DEPTH);

  logic [31:0]       instruction;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] result;
  logic [ADDR_W-1:0] out_rd;
  logic              out_illegal;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output instruction, in_valid, out_ready,
    input  in_ready, result, out_rd, out_illegal, out_valid
  );

  modport slave (
    input  instruction, in_valid, out_ready,
    output in_ready, result, out_rd, out_illegal, out_valid
  );
endinterface

// File: rtl/mp_pipe_core.sv
// Two-stage register-file/ALU execution core: RD (operand read + EX forwarding), EX (ALU + writeback).
// Define MP_MUL_EN to make opcode 10 (unsigned MUL, low DATA_W bits) legal.
module mp_pipe_core #(
  parameter int DATA_W    = 32,
  parameter int REG_DEPTH = 32,
  parameter int OPC_W     = 6
) (
  input logic           clk,
  input logic           rst_n,
  mp_pipe_core_if.slave bus
);
  localparam int ADDR_W = $clog2(REG_DEPTH);
  localparam int SH_W   = $clog2(DATA_W);
  localparam int STAGES = 2;
  localparam int INS_W  = OPC_W + 3*ADDR_W;

  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_SLL = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SRL = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_SLT = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_MOV = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_NOT = OPC_W'(9);
`ifdef MP_MUL_EN
  localparam logic [OPC_W-1:0] OP_MUL = OPC_W'(10);
`endif

  // Field order mirrors the instruction word: opcode in the LSBs, rd on top.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rs1;
    logic [OPC_W-1:0]  opc;
  } rd_stage_t;

  typedef struct packed {
    logic [OPC_W-1:0]  opc;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } ex_stage_t;

  // vld_pipe[0]=RD, [1]=EX, [2]=output register
  logic [STAGES:0]   vld_pipe;
  rd_stage_t         rd_d, rd_q;
  ex_stage_t         ex_q;
  logic [DATA_W-1:0] regs [REG_DEPTH];
  logic [DATA_W-1:0] alu, opa, opb;
  logic              legal, stall, fwd_a, fwd_b;
  logic              unused_ok;

  assign rd_d      = rd_stage_t'(bus.instruction[INS_W-1:0]);
  assign unused_ok = &{1'b0, bus.instruction};

  assign stall         = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = vld_pipe[STAGES];

  always_comb begin
    legal = 1'b1;
    alu   = '0;
    case (ex_q.opc)
      OP_ADD:  alu = ex_q.a + ex_q.b;
      OP_SUB:  alu = ex_q.a - ex_q.b;
      OP_AND:  alu = ex_q.a & ex_q.b;
      OP_OR:   alu = ex_q.a | ex_q.b;
      OP_XOR:  alu = ex_q.a ^ ex_q.b;
      OP_SLL:  alu = ex_q.a << ex_q.b[SH_W-1:0];
      OP_SRL:  alu = ex_q.a >> ex_q.b[SH_W-1:0];
      OP_SLT:  alu = DATA_W'($signed(ex_q.a) < $signed(ex_q.b));
      OP_MOV:  alu = ex_q.a;
      OP_NOT:  alu = ~ex_q.a;
`ifdef MP_MUL_EN
      OP_MUL:  alu = ex_q.a * ex_q.b;
`endif
      default: begin
        legal = 1'b0;
        alu   = '0;
      end
    endcase
  end

  // The EX instruction has not written back yet, so a matching read takes its ALU value.
  assign fwd_a = vld_pipe[1] & legal & (ex_q.rd == rd_q.rs1);
  assign fwd_b = vld_pipe[1] & legal & (ex_q.rd == rd_q.rs2);
  assign opa   = fwd_a ? alu : regs[rd_q.rs1];
  assign opb   = fwd_b ? alu : regs[rd_q.rs2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe        <= '0;
      bus.result      <= '0;
      bus.out_rd      <= '0;
      bus.out_illegal <= 1'b0;
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], bus.in_valid};
      if (bus.in_valid) rd_q <= rd_d;
      ex_q <= '{opc: rd_q.opc, rd: rd_q.rd, a: opa, b: opb};
      bus.result      <= alu;
      bus.out_rd      <= ex_q.rd;
      bus.out_illegal <= ~legal;
      if (vld_pipe[1] && legal) regs[ex_q.rd] <= alu;
    end
  end
endmodule

// File: tb/tb_mp_pipe_core.sv
// Self-checking bench for mp_pipe_core: vector table plus stall and mid-flight reset sequences.
module tb_mp_pipe_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mp_pipe_core_if #(.DATA_W(32), .REG_DEPTH(32)) bus_if ();

  mp_pipe_core #(.DATA_W(32), .REG_DEPTH(32), .OPC_W(6)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  exp_t q[$];
  vec_t tbl[$];
  exp_t e_mon;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] mk(input int opc, input int rd, input int rs1, input int rs2);
    return {11'd0, 5'(rd), 5'(rs2), 5'(rs1), 6'(opc)};
  endfunction

  function automatic void add(input int opc, input int rd, input int rs1, input int rs2,
                              input logic [31:0] res, input logic ill);
    vec_t v;
    v.ins = mk(opc, rd, rs1, rs2);
    v.res = res;
    v.rd  = 5'(rd);
    v.ill = ill;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every retirement must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus_if.out_valid && bus_if.out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL retire: unexpected output rd=%0d result=%0h illegal=%0b",
                 bus_if.out_rd, bus_if.result, bus_if.out_illegal);
      end else begin
        e_mon = q.pop_front();
        if (bus_if.result !== e_mon.res || bus_if.out_rd !== e_mon.rd ||
            bus_if.out_illegal !== e_mon.ill) begin
          errors++;
          $display("FAIL retire: got rd=%0d result=%0h illegal=%0b, expected rd=%0d result=%0h illegal=%0b",
                   bus_if.out_rd, bus_if.result, bus_if.out_illegal, e_mon.rd, e_mon.res, e_mon.ill);
        end
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] er, input logic [4:0] erd,
                      input logic eill, input bit push);
    int n = 0;
    bus_if.instruction = ins;
    bus_if.in_valid    = 1'b1;
    if (push) q.push_back('{er, erd, eill});
    forever begin
      @(negedge clk);
      if (bus_if.in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept: in_ready stuck low for %0d cycles", n);
        break;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus_if.instruction = '0;
    bus_if.in_valid    = 1'b0;
    bus_if.out_ready   = 1'b1;
    rst_n              = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_out_valid",   32'(bus_if.out_valid),   32'd0);
    chk("rst_result",      bus_if.result,           32'd0);
    chk("rst_out_rd",      32'(bus_if.out_rd),      32'd0);
    chk("rst_out_illegal", 32'(bus_if.out_illegal), 32'd0);
    chk("rst_in_ready",    32'(bus_if.in_ready),    32'd1);

    // MOV R1,R0: out_valid rises only after the second edge following accept
    @(posedge clk);
    #1;
    send(mk(8, 1, 0, 0), 32'd0, 5'd1, 1'b0, 1'b1);
    bus_if.in_valid = 1'b0;
    @(negedge clk); chk("lat_edge1", 32'(bus_if.out_valid), 32'd0);
    @(negedge clk); chk("lat_edge2", 32'(bus_if.out_valid), 32'd0);
    @(negedge clk); chk("lat_edge3", 32'(bus_if.out_valid), 32'd1);
    drain();

    // Constants are built from R0 back-to-back, so most rows lean on forwarding.
    add(9, 1, 0, 0, 32'hFFFF_FFFF, 1'b0);  // NOT  R1 = ~R0
    add(1, 2, 0, 1, 32'd1, 1'b0);          // SUB  R2 = R0 - R1
    add(0, 3, 2, 2, 32'd2, 1'b0);          // ADD  R3 = R2 + R2
    add(0, 4, 3, 3, 32'd4, 1'b0);
    add(0, 5, 4, 2, 32'd5, 1'b0);
    add(0, 6, 5, 3, 32'd7, 1'b0);
    add(8, 2, 5, 0, 32'd5, 1'b0);          // MOV  R2 = 5 (distance 2 via regfile)
    add(8, 3, 6, 0, 32'd7, 1'b0);          // MOV  R3 = 7
    add(0, 4, 2, 3, 32'd12, 1'b0);         // ADD  R4 = R2 + R3
    add(8, 5, 4, 0, 32'd12, 1'b0);         // MOV  R5 = R4
    add(0, 6, 2, 3, 32'd12, 1'b0);
    add(1, 7, 6, 2, 32'd7, 1'b0);          // SUB  R7 = R6 - R2, back-to-back
    add(2, 8, 2, 3, 32'd5, 1'b0);          // AND
    add(3, 9, 2, 6, 32'd13, 1'b0);         // OR
    add(4, 10, 3, 6, 32'd11, 1'b0);        // XOR
    add(5, 11, 2, 3, 32'd640, 1'b0);       // SLL 5 << 7
    add(6, 12, 1, 3, 32'h01FF_FFFF, 1'b0); // SRL logical
    add(7, 13, 1, 2, 32'd1, 1'b0);         // SLT -1 < 5
    add(7, 14, 2, 1, 32'd0, 1'b0);         // SLT 5 < -1
    add(1, 15, 2, 3, 32'hFFFF_FFFE, 1'b0); // SUB wraps
    add(0, 16, 1, 2, 32'd4, 1'b0);         // ADD wraps
    add(63, 2, 3, 3, 32'd0, 1'b1);         // illegal, must not touch R2
    add(8, 17, 2, 0, 32'd5, 1'b0);
`ifdef MP_MUL_EN
    add(10, 18, 2, 3, 32'd35, 1'b0);
    add(8, 19, 18, 0, 32'd35, 1'b0);
`else
    add(10, 18, 2, 3, 32'd0, 1'b1);
    add(8, 19, 18, 0, 32'd0, 1'b0);
`endif
    add(11, 9, 2, 3, 32'd0, 1'b1);         // first code past the legal range
    add(8, 30, 9, 0, 32'd13, 1'b0);
    add(0, 20, 2, 2, 32'd10, 1'b0);
    add(8, 21, 3, 0, 32'd7, 1'b0);
    add(8, 22, 20, 0, 32'd10, 1'b0);
    add(0, 0, 2, 3, 32'd12, 1'b0);         // R0 is writable
    add(8, 23, 0, 0, 32'd12, 1'b0);
    add(8, 25, 2, 0, 32'd5, 1'b0);
    for (int i = 0; i < tbl.size(); i++)
      send(tbl[i].ins, tbl[i].res, tbl[i].rd, tbl[i].ill, 1'b1);
    bus_if.in_valid = 1'b0;
    drain();

    // Backpressure with two in flight, a third waiting at the input.
    bus_if.out_ready = 1'b0;
    send(mk(0, 25, 25, 2), 32'd10, 5'd25, 1'b0, 1'b1);
    send(mk(0, 25, 25, 2), 32'd15, 5'd25, 1'b0, 1'b1);
    bus_if.in_valid = 1'b0;
    @(posedge clk);
    #1;
    bus_if.instruction = mk(8, 26, 25, 0);
    bus_if.in_valid    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready",  32'(bus_if.in_ready),  32'd0);
      chk("stall_out_valid", 32'(bus_if.out_valid), 32'd1);
      chk("stall_result",    bus_if.result,         32'd10);
      chk("stall_out_rd",    32'(bus_if.out_rd),    32'd25);
      @(posedge clk);
      #1;
    end
    bus_if.out_ready = 1'b1;
    send(mk(8, 26, 25, 0), 32'd15, 5'd26, 1'b0, 1'b1);
    bus_if.in_valid = 1'b0;
    drain();

    // Reset with two in flight: neither may retire or write.
    send(mk(0, 28, 2, 3), 32'd0, 5'd0, 1'b0, 1'b0);
    send(mk(0, 29, 28, 2), 32'd0, 5'd0, 1'b0, 1'b0);
    bus_if.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flight_rst_valid", 32'(bus_if.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < 32; r++)
      send(mk(8, 31, r, 0), 32'd0, 5'd31, 1'b0, 1'b1);
    bus_if.in_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
